// File: rtl/rv32i_types.sv
// Shared types for the data-memory access path: FSM state and load/store funct3 codes.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed lane out of a memory read word and sign/zero extends it.
module load_extend
  import rv32i_types::*;
#(
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFF_W  = $clog2(BE_W)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        funct3,
  input  logic [OFF_W-1:0]  offset,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;

  // Move the addressed byte lane down to bit 0, then extend by access width/sign.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (funct3)
      F3_LB:   data = DATA_W'($signed(shifted[7:0]));
      F3_LH:   data = DATA_W'($signed(shifted[15:0]));
      F3_LW:   data = DATA_W'($signed(shifted[31:0]));
      F3_LBU:  data = DATA_W'(shifted[7:0]);
      F3_LHU:  data = DATA_W'(shifted[15:0]);
      F3_LWU:  data = DATA_W'(shifted[31:0]);
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// MEM-stage data memory access: alignment/legality check, lane shifting,
// a three-state handshake with the memory, and load result extension.
// Handshake: a request is taken in IDLE when req_valid is high with exactly one
// of req_read/req_write and no fault; the memory strobe then stays high with
// address/data/mask frozen until dmem_resp, and done pulses one cycle later.
module dmem_access
  import rv32i_types::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFF_W  = $clog2(BE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic [ADDR_W-1:0] dmem_address,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [BE_W-1:0]   mem_byte_enable,
  output logic [BE_W-1:0]   rmask,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              fault,
  output dmem_state_t       dbg_state
);

  dmem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [BE_W-1:0]   rmask_q, rmask_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;

  logic [OFF_W-1:0]  off;
  logic [1:0]        size;
  logic [BE_W-1:0]   base_mask;
  logic [BE_W-1:0]   mask;
  logic              misalign;
  logic              illegal;
  logic              accept;
  logic [DATA_W-1:0] ext_data;

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .rdata  (dmem_rdata),
    .funct3 (funct3_q),
    .offset (off_q),
    .data   (ext_data)
  );

  // Decode the incoming request: lane, byte mask, alignment and legality.
  always_comb begin
    off  = req_addr[OFF_W-1:0];
    size = req_funct3[1:0];
    case (size)
      2'b00:   base_mask = BE_W'(1);
      2'b01:   base_mask = BE_W'(3);
      2'b10:   base_mask = BE_W'(15);
      default: base_mask = '1;
    endcase
    mask = base_mask << off;
    case (size)
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      2'b11:   misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
    if (req_write)
      illegal = req_funct3[2] || (DATA_W == 32 && req_funct3 == F3_SD);
    else
      illegal = (req_funct3 == 3'b111) ||
                (DATA_W == 32 && (req_funct3 == F3_LD || req_funct3 == F3_LWU));
    fault  = req_valid && (req_read || req_write) &&
             ((req_read && req_write) || illegal || misalign);
    accept = !rst && (state_q == IDLE) && req_valid &&
             (req_read ^ req_write) && !fault;
  end

  // Next-state and capture logic for the IDLE -> WAIT -> DONE handshake.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rmask_d     = rmask_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    read_d      = read_q;
    write_d     = write_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
          wdata_d  = req_wdata << {off, 3'b000};
          be_d     = req_write ? mask : '0;
          rmask_d  = req_read ? mask : '0;
          funct3_d = req_funct3;
          off_d    = off;
          read_d   = req_read;
          write_d  = req_write;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (dmem_resp) begin
          if (read_q) load_data_d = ext_data;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset drops strobes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rmask_q     <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rmask_q     <= rmask_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      read_q      <= read_d;
      write_q     <= write_d;
      load_data_q <= load_data_d;
    end
  end

  // Outputs come straight from registers apart from the accept-time stall.
  always_comb begin
    dmem_address    = addr_q;
    dmem_wdata      = wdata_q;
    mem_byte_enable = be_q;
    rmask           = rmask_q;
    load_data       = load_data_q;
    dmem_read       = (state_q == WAIT) && read_q;
    dmem_write      = (state_q == WAIT) && write_q;
    stall           = accept || (state_q == WAIT);
    done            = (state_q == DONE);
    dbg_state       = state_q;
  end

endmodule

// File: doc/dmem_access.md
DMEM_ACCESS -- requirements
Module: dmem_access

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL define the derived constants BE_W = DATA_W/8 and OFF_W = log2(BE_W).
REQ-004 SHALL use one clock; reset is asynchronous and active-high (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have port req_valid  in  1  MEM-stage instruction present.
REQ-008 SHALL have ports req_read, req_write  in  1 each  load op and store op respectively.
REQ-009 SHALL have port req_funct3  in  3  load/store width and sign encoding.
REQ-010 SHALL have port req_addr  in  ADDR_W  byte address (ALU result).
REQ-011 SHALL have port req_wdata  in  DATA_W  unshifted store data (rs2).
REQ-012 SHALL have port dmem_rdata  in  DATA_W  memory read data.
REQ-013 SHALL have port dmem_resp  in  1  memory completion.
REQ-014 SHALL have port dmem_address  out  ADDR_W  aligned address, low OFF_W bits zero.
REQ-015 SHALL have ports dmem_read, dmem_write  out  1 each  memory read and write strobes.
REQ-016 SHALL have port dmem_wdata  out  DATA_W  lane-shifted store data.
REQ-017 SHALL have port mem_byte_enable  out  BE_W  write byte mask.
REQ-018 SHALL have port rmask  out  BE_W  read byte mask, exported for RVFI.
REQ-019 SHALL have port stall  out  1  freeze upstream pipeline.
REQ-020 SHALL have port done  out  1  access complete, one-cycle pulse.
REQ-021 SHALL have port load_data  out  DATA_W  extended load result.
REQ-022 SHALL have port fault  out  1  misaligned or illegal access.

Function
REQ-023 SHALL implement the state machine IDLE -> WAIT -> DONE -> IDLE.
REQ-024 In IDLE, SHALL accept a request when req_valid=1, exactly one of req_read/req_write=1, and fault=0; on accept it registers address, mask, shifted wdata and funct3, then enters WAIT.
REQ-025 SHALL assert dmem_read/dmem_write only in WAIT, driven from registers, with address, data and mask held stable until dmem_resp.
REQ-026 In WAIT, on dmem_resp=1 SHALL register the extended load_data and enter DONE; with no resp it SHALL remain in WAIT indefinitely.
REQ-027 In DONE, SHALL assert done=1 and stall=0 for exactly one cycle, then return to IDLE.
REQ-028 SHALL drive stall = (IDLE and accepting) or WAIT.
REQ-029 Latency: for a request in cycle 0 and dmem_resp in cycle k>=1, done SHALL be asserted in cycle k+1.
REQ-030 Lane offset SHALL be req_addr[OFF_W-1:0]; dmem_wdata SHALL be req_wdata shifted left by offset*8.
REQ-031 Masks SHALL be: byte 1<<off; half 2'b11<<off; word 4'hF<<off; double (64 only) all ones.
REQ-032 Load extraction SHALL use the same lane; lb/lh/lw sign-extend; lbu/lhu/lwu zero-extend.
REQ-033 fault SHALL be combinational: half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0; funct3 011/110 when DATA_W=32; undefined funct3; or req_read and req_write both 1.
REQ-034 On fault, SHALL make no memory access, hold stall=0 and done=0.
REQ-035 SHALL ignore dmem_resp in IDLE and in DONE.
REQ-036 SHALL drive rmask to 0 for stores and mem_byte_enable to 0 for loads.

Reset
REQ-037 While rst=1, SHALL force state=IDLE and dmem_read, dmem_write, stall, done to 0; load_data, dmem_wdata, mem_byte_enable, rmask and dmem_address to 0.
REQ-038 Reset asserted in WAIT SHALL drop strobes immediately; a later stray dmem_resp SHALL have no effect.

Structure
REQ-039 The state enum dmem_state_t and the funct3 encodings SHALL live in rv32i_types.
REQ-040 Lane extraction and extension SHALL be a combinational sub-module, load_extend, parametrised by DATA_W.

Verification
REQ-041 DATA_W=32, lw addr 0x1004, resp after 3 cycles, rdata 0xDEADBEEF -> dmem_address 0x1004, stall for 4 cycles, done pulse, load_data 0xDEADBEEF.
REQ-042 sb addr 0x2003, wdata 0x000000A5 -> mem_byte_enable 4'b1000, dmem_wdata 0xA5000000, dmem_write held until resp.
REQ-043 lh addr 0x3002, rdata 0x8001xxxx -> load_data 0xFFFF8001; lhu -> 0x00008001.
REQ-044 lw addr 0x1002 -> fault=1, no strobe, stall=0; ld with DATA_W=32 -> fault=1.
REQ-045 DATA_W=64, lwu addr 0x4004, rdata 0xF0000000_00000000 -> rmask 8'hF0, load_data 0x00000000_F0000000.
REQ-046 rst in WAIT, then dmem_resp -> strobes drop asynchronously, state IDLE, done never asserts.
